// File: rtl/gate_monitor.sv
// gate_monitor: per-leg dead interval and shoot-through checker
// for the six gate signals leaving the deadtime stage.
module gate_monitor (
  input  logic        CLK,
  input  logic        ARESETN,
  input  logic        U,
  input  logic        V,
  input  logic        W,
  input  logic        X,
  input  logic        Y,
  input  logic        Z,
  input  logic [15:0] PRM_MIN_DEADTIME,
  input  logic        CARRIER_PEAK,
  input  logic        LOAD,
  input  logic        FAULT_CLR,
  output logic [15:0] DT_MEAS_U,
  output logic [15:0] DT_MEAS_V,
  output logic [15:0] DT_MEAS_W,
  output logic [2:0]  MEAS_VALID,
  output logic [2:0]  DT_SHORT,
  output logic [2:0]  SHOOT_THROUGH,
  output logic        FAULT
);

  typedef enum logic [2:0] {
    S_INIT,
    S_ON_H,
    S_ON_L,
    S_DEAD_H,
    S_DEAD_L,
    S_SHOOT
  } leg_state_t;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [2:0]  h_q;
  logic [2:0]  l_q;
  logic [15:0] min_q;

  leg_state_t  state_q [3];
  leg_state_t  state_d [3];
  logic [15:0] cnt_q   [3];
  logic [15:0] cnt_d   [3];
  logic [15:0] meas_n  [3];
  logic [15:0] meas_q  [3];
  logic [2:0]  meas_en;
  logic [2:0]  short_set;
  logic [2:0]  st_set;

  logic [2:0]  meas_valid_q;
  logic [2:0]  dt_short_q;
  logic [2:0]  shoot_q;
  logic        fault_q;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      meas_n[i]  = 16'd0;
      meas_en[i] = 1'b0;
      st_set[i]  = 1'b0;
      if (h_q[i] && l_q[i]) begin
        state_d[i] = S_SHOOT;
        st_set[i]  = 1'b1;
      end else begin
        unique case (state_q[i])
          S_INIT, S_SHOOT: begin
            unique case (1'b1)
              h_q[i]:  state_d[i] = S_ON_H;
              l_q[i]:  state_d[i] = S_ON_L;
              default: state_d[i] = S_INIT;
            endcase
          end
          S_ON_H: begin
            unique case (1'b1)
              l_q[i]: begin
                state_d[i] = S_ON_L;
                meas_en[i] = 1'b1;
              end
              h_q[i]:  state_d[i] = S_ON_H;
              default: begin
                state_d[i] = S_DEAD_H;
                cnt_d[i]   = 16'd1;
              end
            endcase
          end
          S_ON_L: begin
            unique case (1'b1)
              h_q[i]: begin
                state_d[i] = S_ON_H;
                meas_en[i] = 1'b1;
              end
              l_q[i]:  state_d[i] = S_ON_L;
              default: begin
                state_d[i] = S_DEAD_L;
                cnt_d[i]   = 16'd1;
              end
            endcase
          end
          S_DEAD_H, S_DEAD_L: begin
            unique case (1'b1)
              h_q[i]: begin
                state_d[i] = S_ON_H;
                meas_en[i] = (state_q[i] == S_DEAD_L);
                meas_n[i]  = cnt_q[i];
              end
              l_q[i]: begin
                state_d[i] = S_ON_L;
                meas_en[i] = (state_q[i] == S_DEAD_H);
                meas_n[i]  = cnt_q[i];
              end
              default: begin
                if (cnt_q[i] != CNT_MAX)
                  cnt_d[i] = cnt_q[i] + 16'd1;
              end
            endcase
          end
          default: state_d[i] = S_INIT;
        endcase
      end
      short_set[i] = meas_en[i] &&
                     (min_q != 16'd0) &&
                     (meas_n[i] < min_q);
    end
  end

  always_ff @(posedge CLK or negedge ARESETN) begin
    if (!ARESETN) begin
      h_q <= '0;
      l_q <= '0;
      min_q <= '0;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= S_INIT;
        cnt_q[i]   <= '0;
        meas_q[i]  <= '0;
      end
      meas_valid_q <= '0;
      dt_short_q   <= '0;
      shoot_q      <= '0;
      fault_q      <= 1'b0;
    end else begin
      h_q <= {W, V, U};
      l_q <= {Z, Y, X};
      if (CARRIER_PEAK || LOAD)
        min_q <= PRM_MIN_DEADTIME;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        if (meas_en[i])
          meas_q[i] <= meas_n[i];
      end
      meas_valid_q <= meas_en;
      // a fresh violation outranks a simultaneous clear
      dt_short_q <= (dt_short_q & {3{~FAULT_CLR}})
                  | short_set;
      shoot_q    <= (shoot_q & {3{~FAULT_CLR}})
                  | st_set;
      fault_q    <= (|dt_short_q) | (|shoot_q);
    end
  end

  assign DT_MEAS_U     = meas_q[0];
  assign DT_MEAS_V     = meas_q[1];
  assign DT_MEAS_W     = meas_q[2];
  assign MEAS_VALID    = meas_valid_q;
  assign DT_SHORT      = dt_short_q;
  assign SHOOT_THROUGH = shoot_q;
  assign FAULT         = fault_q;

endmodule

// File: doc/gate_monitor.md
# gate_monitor

Per-phase checker for the six gate signals leaving the deadtime stage of the three-phase PWM modulator. For each leg (U/X, V/Y, W/Z) it measures the dead interval at every commutation, flags intervals shorter than a programmable minimum, and flags shoot-through (both switches of a leg on together). Flags are sticky and ORed into a single FAULT output for the protection logic. It sits downstream of the deadtime generator, or at the gate-driver pins via loopback.

## Interface
- No parameters; all widths fixed.
- CLK  in  1  system clock, rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- U, V, W  in  1 each  upper-switch gate signals, active high.
- X, Y, Z  in  1 each  lower-switch gate signals, active high; X pairs with U, Y with V, Z with W.
- PRM_MIN_DEADTIME  in  16  minimum legal dead interval, in clocks; 0 disables the short check.
- CARRIER_PEAK  in  1  one-clock pulse; loads PRM_MIN_DEADTIME.
- LOAD  in  1  one-clock pulse; loads PRM_MIN_DEADTIME.
- FAULT_CLR  in  1  clears all sticky flags.
- DT_MEAS_U, DT_MEAS_V, DT_MEAS_W  out  16 each  last measured dead interval per leg.
- MEAS_VALID  out  3  one-clock pulse per leg when its DT_MEAS updates; bit0=U, bit1=V, bit2=W.
- DT_SHORT  out  3  sticky short-deadtime flag per leg.
- SHOOT_THROUGH  out  3  sticky shoot-through flag per leg.
- FAULT  out  1  registered OR of DT_SHORT and SHOOT_THROUGH.

## Operation
- Input stage: one register per gate input (H = upper, L = lower). All logic below uses these samples.
- Min register: reset value 16'd0. Loads PRM_MIN_DEADTIME on any edge where CARRIER_PEAK | LOAD is high. A measurement compares against the register value before that edge's load.
- Per-leg FSM, states INIT, ON_H, ON_L, DEAD_H, DEAD_L, SHOOT. Sample codes are (H,L):
  - Any state, (1,1) -> SHOOT; set SHOOT_THROUGH[leg].
  - INIT: (1,0) -> ON_H; (0,1) -> ON_L; (0,0) -> stay. No measurement.
  - ON_H: (0,0) -> DEAD_H, counter = 1. (0,1) is a direct commutation -> ON_L with measurement N = 0.
  - ON_L: symmetric with ON_H; (0,0) -> DEAD_L.
  - DEAD_H: (0,0) -> counter + 1, saturating at 16'hFFFF. (1,0) -> ON_H with no measurement, because the same switch returned. (0,1) -> ON_L with measurement N = counter.
  - DEAD_L: symmetric with DEAD_H.
  - SHOOT: (1,0) -> ON_H; (0,1) -> ON_L; (0,0) -> INIT. No measurement on any exit.
- Measurement: DT_MEAS_leg <= N and MEAS_VALID[leg] <= 1 for one clock. If N < min register and the min register != 0, set DT_SHORT[leg].
- N is the number of consecutive rising edges at which both samples were low. It saturates at 65535.
- Sticky flags: FAULT_CLR clears all six flags. A new violation detected on the same edge as FAULT_CLR wins, and that flag stays set.
- Legs are fully independent; simultaneous events on several legs are all handled in the same cycle.

## Timing
- Reset values: DT_MEAS_* = 0, MEAS_VALID = 0, DT_SHORT = 0, SHOOT_THROUGH = 0, FAULT = 0, all FSMs in INIT, min register = 0, input registers = 0.
- Latency: a gate change is captured at edge k. The FSM, DT_MEAS, MEAS_VALID, DT_SHORT and SHOOT_THROUGH update at edge k+1. FAULT updates at edge k+2.
- A dead interval of D clocks at the pins gives N = D.
- ARESETN asserted mid-interval: all state is discarded immediately. After release the legs restart in INIT, and the first commutation is not measured.
- Counter saturation at 16'hFFFF: no wrap, and the FSM stays in DEAD_x.

## Test plan
- Reset release with all gates low -> all outputs 0. Then U=1 -> leg U in ON_H, no MEAS_VALID.
- U=1, X=0. Drop U, hold both low 50 clocks, raise X; min register = 40 -> DT_MEAS_U = 50, MEAS_VALID[0] pulses once 2 clocks after X rises at the pin, DT_SHORT[0] = 0.
- Same sequence with PRM_MIN_DEADTIME = 60 loaded by LOAD -> DT_MEAS_U = 50, DT_SHORT[0] = 1, FAULT = 1 one clock later. FAULT_CLR pulse -> flags and FAULT return to 0.
- V and Y both high for 1 clock -> SHOOT_THROUGH[1] = 1 and FAULT = 1. The following commutation produces no MEAS_VALID[1].
- W drops, stays low 20 clocks, W rises again with Z low -> no MEAS_VALID[2], DT_MEAS_W unchanged.
- FAULT_CLR on the same edge as a new short detection on leg U -> DT_SHORT[0] remains 1. A 70000-clock dead interval -> DT_MEAS = 16'hFFFF.
